child_motion: RTL and testbench
===============================

Name: child_motion

Overview:
- Sequential position controller for the "child" sprite on the 640x480 VGA playfield.
- Once per video frame, it updates the sprite's registered center coordinates from USB keyboard keycodes: walk left/right and jump with gravity.
- Its centerx/centery outputs feed the sprite hit-test and drawing logic, which uses a 26-pixel half-width and 30-pixel half-height box around the center. All limits below keep that whole box on screen.

Parameters:
- X_START, 320, reset center X
- X_MIN, 26, minimum center X (left edge of box reaches column 0)
- X_MAX, 613, maximum center X (right edge of box reaches column 639)
- Y_MIN, 30, minimum center Y (ceiling)
- GROUND_Y, 449, resting center Y (bottom edge of box reaches row 479)
- STEP_X, 3, horizontal pixels per frame while walking
- JUMP_V, 12, initial upward speed in pixels per frame
- MAX_FALL, 12, cap on downward speed

Ports:
- Clk  in  1  system clock (pixel/system domain)
- Reset_n  in  1  asynchronous active-low reset
- vs  in  1  VGA vertical sync, active-low, synchronous to Clk
- keycode0  in  8  USB HID keycode slot 0 (0x00 = none)
- keycode1  in  8  USB HID keycode slot 1
- centerx  out  10  sprite center X
- centery  out  10  sprite center Y
- in_air  out  1  1 while jumping or falling
- facing_left  out  1  last horizontal direction (1 = left)
- frame_tick  out  1  one-Clk pulse marking each position update

Behaviour:
- Reset (Reset_n=0, asynchronous): centerx=X_START, centery=GROUND_Y, vy=0, state GROUND, in_air=0, facing_left=0, frame_tick=0, vs_d=1.
  - Deasserting reset mid-jump discards all motion.
- Frame tick:
  - vs_d <= vs on every Clk.
  - tick = vs_d & ~vs, i.e. the falling edge of vs.
  - frame_tick is registered and pulses high for exactly 1 Clk, in the cycle after the update edge.
- All position and velocity state changes only on a Clk edge where tick=1. Between ticks, outputs are held.
- Key decode, with both slots ORed together:
  - left = 0x04 (A)
  - right = 0x07 (D)
  - jump = 0x2C (space)
  - All other codes are ignored.
- Horizontal motion, evaluated in every state:
  - left only: x_next = centerx - STEP_X; facing_left <= 1.
  - right only: x_next = centerx + STEP_X; facing_left <= 0.
  - both or neither: x unchanged, facing_left unchanged.
  - Compute in 11-bit signed, then clamp to [X_MIN, X_MAX] (no wrap at 0 or 1023).
- Vertical state machine, using vy as 6-bit signed velocity:
  - GROUND, jump pressed at tick: vy <= -JUMP_V, state -> AIR, centery unchanged on this tick, in_air <= 1.
  - GROUND, jump not pressed: no vertical change.
  - AIR, each tick: y_next = centery + vy, computed 11-bit signed; then vy <= min(vy+1, MAX_FALL).
  - AIR, if y_next >= GROUND_Y: centery <= GROUND_Y, vy <= 0, state -> GROUND, in_air <= 0.
  - AIR, else if y_next < Y_MIN: centery <= Y_MIN, vy <= 0 (ceiling bump; next ticks fall).
  - AIR, else: centery <= y_next.
  - Holding jump while in AIR has no effect. Holding jump on landing re-triggers on the next tick, not the landing tick.
- Horizontal and vertical updates occur on the same tick, independently.
- Latency: a keycode present at the vs falling edge affects outputs on that edge; a key change between ticks is invisible.
- Synthesizable RTL with one always_ff and combinational next-state logic; no latches.

Test Plan:
- Reset -> centerx=320, centery=449, in_air=0, facing_left=0; outputs stable with keycodes 0x00 over 5 frames.
- keycode0=0x07 held 10 frames -> centerx=350, facing_left=0. Then keycode0=0x04, keycode1=0x07 for 3 frames -> centerx stays 350.
- Walk left from centerx=30: frame 1 -> 27, frame 2 -> 26, frame 3 -> 26 (clamped, no wrap), facing_left=1. Repeat at the right edge: from 611 -> 613 and holds.
- keycode1=0x2C for one frame from GROUND:
  - jump tick: y=449, vy=-12, in_air=1.
  - after 12 further ticks: y=371.
  - lands at 449 on air tick 25; in_air=0 in the same update.
  - frame_tick pulses once per vs fall, 1 Clk wide.
- Hold space + D continuously -> jumps repeat with a 1-frame ground dwell, x advances 3/frame throughout. Assert Reset_n=0 mid-air (y=400) -> immediate 320/449, in_air=0, independent of Clk.
- vs toggling without falling edges (held low 3 frames) -> no updates. Glitch-free single tick when vs falls after reset, with vs_d=1.

Source files
------------

// File: rtl/child_motion.sv
// Child sprite position controller: per-frame walk and jump-with-gravity update
// of the sprite center, stepped on each falling edge of VGA vsync.
module child_motion #(
  parameter int X_START  = 320,
  parameter int X_MIN    = 26,
  parameter int X_MAX    = 613,
  parameter int Y_MIN    = 30,
  parameter int GROUND_Y = 449,
  parameter int STEP_X   = 3,
  parameter int JUMP_V   = 12,
  parameter int MAX_FALL = 12
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] centerx,
  output logic [9:0] centery,
  output logic       in_air,
  output logic       facing_left,
  output logic       frame_tick
);

  typedef enum logic {GROUND, AIR} state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h2C;

  localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic signed [10:0] STEP_S   = 11'(STEP_X);
  localparam logic signed [5:0]  JUMP_S   = 6'(-JUMP_V);
  localparam logic signed [5:0]  MAXF_S   = 6'(MAX_FALL);

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic signed [5:0]  vy_q, vy_d, vy_inc;
  logic               facing_q, facing_d;
  logic               vs_q, tick, tick_q;
  logic               key_left, key_right, key_jump;
  logic signed [10:0] x_calc, y_calc;

  assign tick      = vs_q & ~vs;
  assign key_left  = (keycode0 == KEY_LEFT)  | (keycode1 == KEY_LEFT);
  assign key_right = (keycode0 == KEY_RIGHT) | (keycode1 == KEY_RIGHT);
  assign key_jump  = (keycode0 == KEY_JUMP)  | (keycode1 == KEY_JUMP);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    facing_d = facing_q;
    x_calc   = $signed({1'b0, x_q});
    y_calc   = $signed({1'b0, y_q}) + $signed({{5{vy_q[5]}}, vy_q});
    vy_inc   = (vy_q >= MAXF_S) ? MAXF_S : vy_q + 6'sd1;

    if (tick) begin
      // 11-bit signed math so a step past either edge clamps instead of wrapping
      if (key_left && !key_right) begin
        x_calc   = x_calc - STEP_S;
        facing_d = 1'b1;
      end else if (key_right && !key_left) begin
        x_calc   = x_calc + STEP_S;
        facing_d = 1'b0;
      end
      if (x_calc < XMIN_S)      x_d = 10'(X_MIN);
      else if (x_calc > XMAX_S) x_d = 10'(X_MAX);
      else                      x_d = x_calc[9:0];

      unique case (state_q)
        GROUND: begin
          if (key_jump) begin
            vy_d    = JUMP_S;
            state_d = AIR;
          end
        end
        AIR: begin
          if (y_calc >= GROUND_S) begin
            y_d     = 10'(GROUND_Y);
            vy_d    = '0;
            state_d = GROUND;
          end else if (y_calc < YMIN_S) begin
            y_d  = 10'(Y_MIN);
            vy_d = '0;
          end else begin
            y_d  = y_calc[9:0];
            vy_d = vy_inc;
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= GROUND;
      x_q      <= 10'(X_START);
      y_q      <= 10'(GROUND_Y);
      vy_q     <= '0;
      facing_q <= 1'b0;
      vs_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      facing_q <= facing_d;
      vs_q     <= vs;
      tick_q   <= tick;
    end
  end

  assign centerx     = x_q;
  assign centery     = y_q;
  assign in_air      = (state_q == AIR);
  assign facing_left = facing_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_child_motion.sv
// Bench for child_motion: integer reference model of walk/jump physics, per-cycle
// output compare, plus literal checkpoints from hand-worked trajectories.
module tb_child_motion;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       vs = 1'b1;
  logic [7:0] keycode0 = '0;
  logic [7:0] keycode1 = '0;
  logic [9:0] centerx, centery;
  logic       in_air, facing_left, frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int m_x, m_y, m_vy, m_air, m_face, exp_ft;
  bit chk_en = 1'b0;

  child_motion #(
    .X_START(320), .X_MIN(26), .X_MAX(613), .Y_MIN(30), .GROUND_Y(449),
    .STEP_X(3), .JUMP_V(12), .MAX_FALL(12)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .keycode0(keycode0), .keycode1(keycode1),
    .centerx(centerx), .centery(centery), .in_air(in_air),
    .facing_left(facing_left), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_x = 320; m_y = 449; m_vy = 0; m_air = 0; m_face = 0; exp_ft = 0;
  endfunction

  function automatic void model_step(input logic [7:0] a, input logic [7:0] b);
    bit l, r, j;
    int yn;
    l = (a == 8'h04) || (b == 8'h04);
    r = (a == 8'h07) || (b == 8'h07);
    j = (a == 8'h2C) || (b == 8'h2C);
    if (l && !r) begin
      m_x = (m_x - 3 < 26) ? 26 : m_x - 3;
      m_face = 1;
    end else if (r && !l) begin
      m_x = (m_x + 3 > 613) ? 613 : m_x + 3;
      m_face = 0;
    end
    if (m_air == 0) begin
      if (j) begin m_vy = -12; m_air = 1; end
    end else begin
      yn = m_y + m_vy;
      if (yn >= 449)     begin m_y = 449; m_vy = 0; m_air = 0; end
      else if (yn < 30)  begin m_y = 30;  m_vy = 0; end
      else begin m_y = yn; m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1; end
    end
  endfunction

  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("centerx", int'(centerx), m_x);
      cmp("centery", int'(centery), m_y);
      cmp("in_air", int'(in_air), m_air);
      cmp("facing_left", int'(facing_left), m_face);
      cmp("frame_tick", int'(frame_tick), exp_ft);
    end
  end

  // One frame: keys present at the vs fall are used; junk keys afterwards must be ignored.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input int low, input int high);
    @(posedge Clk); #1;
    keycode0 = a; keycode1 = b; vs = 1'b0;
    @(posedge Clk); #1;
    model_step(a, b);
    exp_ft = 1;
    keycode0 = 8'($urandom); keycode1 = 8'($urandom);
    @(posedge Clk); #1;
    exp_ft = 0;
    repeat (low) @(posedge Clk);
    #1 vs = 1'b1;
    repeat (high) @(posedge Clk);
    #2;
  endtask

  task automatic async_reset();
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    model_reset();
    #1;
    cmp("rst_x", int'(centerx), 320);
    cmp("rst_y", int'(centery), 449);
    cmp("rst_air", int'(in_air), 0);
    cmp("rst_face", int'(facing_left), 0);
    cmp("rst_ft", int'(frame_tick), 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] ktab [5];
    logic [7:0] ka, kb;
    int x0, guard;
    ktab[0] = 8'h00; ktab[1] = 8'h04; ktab[2] = 8'h07; ktab[3] = 8'h2C; ktab[4] = 8'h15;

    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // idle frames
    repeat (5) frame(8'h00, 8'h00, 2, 3);
    cmp("idle_x", int'(centerx), 320);
    cmp("idle_y", int'(centery), 449);

    // walk right, then both directions cancel
    repeat (10) frame(8'h07, 8'h00, 2, 3);
    cmp("walk_r_x", int'(centerx), 350);
    cmp("walk_r_face", int'(facing_left), 0);
    repeat (3) frame(8'h04, 8'h07, 1, 2);
    cmp("both_x", int'(centerx), 350);

    // left clamp
    async_reset();
    repeat (96) frame(8'h04, 8'h00, 1, 1);
    cmp("left_32", int'(centerx), 32);
    frame(8'h04, 8'h00, 1, 1);
    cmp("left_29", int'(centerx), 29);
    frame(8'h04, 8'h00, 1, 1);
    cmp("left_26", int'(centerx), 26);
    frame(8'h00, 8'h04, 1, 1);
    cmp("left_hold", int'(centerx), 26);
    cmp("left_face", int'(facing_left), 1);

    // right clamp
    repeat (195) frame(8'h07, 8'h00, 1, 1);
    cmp("right_611", int'(centerx), 611);
    frame(8'h07, 8'h00, 1, 1);
    cmp("right_613", int'(centerx), 613);
    frame(8'h00, 8'h07, 1, 1);
    cmp("right_hold", int'(centerx), 613);
    cmp("right_face", int'(facing_left), 0);

    // single jump trajectory
    async_reset();
    frame(8'h00, 8'h2C, 2, 2);
    cmp("jump_y", int'(centery), 449);
    cmp("jump_air", int'(in_air), 1);
    repeat (12) frame(8'h00, 8'h00, 2, 2);
    cmp("apex_y", int'(centery), 371);
    repeat (12) frame(8'h00, 8'h00, 2, 2);
    cmp("fall_y", int'(centery), 437);
    cmp("fall_air", int'(in_air), 1);
    frame(8'h00, 8'h00, 2, 2);
    cmp("land_y", int'(centery), 449);
    cmp("land_air", int'(in_air), 0);

    // repeated jumps while walking, then reset mid-air
    async_reset();
    repeat (60) frame(8'h07, 8'h2C, 1, 1);
    cmp("hop_x", int'(centerx), 500);
    guard = 0;
    while (!(m_air == 1 && m_y < 420) && guard < 40) begin
      frame(8'h07, 8'h2C, 1, 1);
      guard++;
    end
    cmp("midair_found", int'(guard < 40), 1);
    async_reset();

    // vs held low across several frame periods: one update only
    x0 = m_x;
    frame(8'h07, 8'h00, 30, 2);
    cmp("vs_low_x", int'(centerx), x0 + 3);

    // vs already low when reset releases: exactly one tick
    @(posedge Clk); #3;
    Reset_n = 1'b0; vs = 1'b0; keycode0 = 8'h07; keycode1 = 8'h00;
    model_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    model_step(8'h07, 8'h00);
    exp_ft = 1;
    cmp("post_rst_tick", int'(frame_tick), 1);
    @(posedge Clk); #1;
    exp_ft = 0;
    repeat (5) @(posedge Clk);
    #1;
    cmp("post_rst_x", int'(centerx), 323);
    vs = 1'b1;
    repeat (2) @(posedge Clk);
    #2;

    // randomized frames
    repeat (300) begin
      ka = ktab[$urandom_range(0, 4)];
      kb = ktab[$urandom_range(0, 4)];
      frame(ka, kb, $urandom_range(1, 4), $urandom_range(1, 6));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
